// File: rtl/polar_piso_buf_if.sv
// Handshake bundle for the polar encoder PISO buffer: parallel load side,
// serial output side and occupancy status.
interface polar_piso_buf_if #(
  parameter int N = 1024
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_bit;
  logic         out_sop;
  logic         out_eop;
  logic [1:0]   level;
  logic         empty;
  logic         full;

  // Producer/consumer side: offers codewords, accepts serial bits.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bit, out_sop, out_eop, level, empty, full
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bit, out_sop, out_eop, level, empty, full
  );
endinterface

// File: rtl/polar_piso_buf.sv
// Ping-pong parallel-in/serial-out buffer. Two N-bit slots: one shifts out
// while the other is refilled, so back-to-back frames stream without gaps.
// All outputs decode registered state; in_ready never depends on out_ready.
module polar_piso_buf #(
  parameter int N         = 1024,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  polar_piso_buf_if.slave  bus
);
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  logic [N-1:0]     slot_q [2];
  logic [1:0]       vld_q, vld_d;
  logic             wsel_q, wsel_d;
  logic             rsel_q, rsel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load;
  logic             beat;
  logic             last;
  logic [CNT_W-1:0] idx;

  assign bus.in_ready  = ~vld_q[wsel_q];
  assign bus.out_valid = vld_q[rsel_q];

  assign load = bus.in_valid & ~vld_q[wsel_q];
  assign beat = vld_q[rsel_q] & bus.out_ready;
  assign last = (cnt_q == LAST_IDX);

  // Bit order is fixed at elaboration; the counter always runs upward.
  assign idx = MSB_FIRST ? (LAST_IDX - cnt_q) : cnt_q;

  assign bus.out_bit = vld_q[rsel_q] ? slot_q[rsel_q][idx] : 1'b0;
  assign bus.out_sop = vld_q[rsel_q] & (cnt_q == '0);
  assign bus.out_eop = vld_q[rsel_q] & last;

  assign bus.level = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};
  assign bus.empty = (vld_q == 2'b00);
  assign bus.full  = (vld_q == 2'b11);

  // Next-state: a load and a final beat always target different slots
  // (load needs vld[wsel]=0, beat needs vld[rsel]=1), so both may apply.
  always_comb begin
    vld_d  = vld_q;
    wsel_d = wsel_q;
    rsel_d = rsel_q;
    cnt_d  = cnt_q;
    if (beat) begin
      if (last) begin
        cnt_d         = '0;
        vld_d[rsel_q] = 1'b0;
        rsel_d        = ~rsel_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (load) begin
      vld_d[wsel_q] = 1'b1;
      wsel_d        = ~wsel_q;
    end
  end

  // Control state; reset drops both queued and in-flight frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 2'b00;
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      cnt_q  <= cnt_d;
    end
  end

  // Slot storage is data only: captured on a transfer, never cleared.
  always_ff @(posedge clk) begin
    if (load && !reset) begin
      slot_q[wsel_q] <= bus.in_data;
    end
  end
endmodule
